// File: rtl/lcd_tx_pkg.sv
// Shared types and constants for the RGB565 SPI pixel transmitter.
// Holds the serializer state encoding and the optional byte-swap helper.
package lcd_tx_pkg;

    localparam int RGB565_W     = 16;
    localparam int BITS_PER_PIX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } tx_state_e;

    function automatic logic [RGB565_W-1:0] byte_swap(input logic [RGB565_W-1:0] d);
        return {d[7:0], d[15:8]};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with occupancy output; push and pop may coincide,
// including a push into a full FIFO that is being popped in the same cycle.
module pixel_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_level;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_level == '0);
    assign o_full   = (r_level == (AW+1)'(DEPTH));
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_rdata  = r_mem[r_rdPtr];
    assign o_level  = r_level;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            if (w_doPush && !w_doPop)      r_level <= r_level + 1'b1;
            else if (!w_doPush && w_doPop) r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
    end

endmodule

// File: rtl/lcd_spi_pixel_tx.sv
// RGB565 pixel FIFO plus mode-0 SPI serializer with per-frame chip select.
// Define LCD_TX_BYTESWAP_EN to send the low byte of each pixel first.
module lcd_spi_pixel_tx
    import lcd_tx_pkg::*;
#(
    parameter int FIFO_DEPTH       = 16,
    parameter int CLK_DIV          = 2,
    parameter int PIXELS_PER_FRAME = 76800
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [RGB565_W-1:0]           pix_data,
    input  logic                          pix_valid,
    input  logic                          clr_ovf,
    output logic                          spi_sclk,
    output logic                          spi_mosi,
    output logic                          spi_cs_n,
    output logic                          spi_dc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_done,
    output logic                          busy
);

    localparam int FC_W  = $clog2(PIXELS_PER_FRAME + 1);
    localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
    localparam int BIT_W = $clog2(BITS_PER_PIX);

    tx_state_e             r_state;
    tx_state_e             w_nextState;
    logic [RGB565_W-1:0]   w_fifoData;
    logic [RGB565_W-1:0]   w_loadWord;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_avail;
    logic                  w_tick;
    logic                  w_pixDone;
    logic                  w_frameEnd;
    logic                  w_gapEnd;
    logic [RGB565_W-1:0]   r_shift;
    logic [DIV_W-1:0]      r_div;
    logic [BIT_W-1:0]      r_bitCnt;
    logic [FC_W-1:0]       r_frameCnt;
    logic                  r_hold;
    logic                  r_sclk;
    logic                  r_csN;
    logic                  r_dc;
    logic                  r_ovf;
    logic                  r_frameDone;
    logic                  r_busy;

    pixel_fifo #(
        .WIDTH (RGB565_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (pix_valid),
        .i_wdata (pix_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifoData),
        .o_level (fifo_level),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

`ifdef LCD_TX_BYTESWAP_EN
    assign w_loadWord = byte_swap(w_fifoData);
`else
    assign w_loadWord = w_fifoData;
`endif

    // A pixel being pushed this cycle counts as available so IDLE reaches LOAD one cycle after the push.
    assign w_pop      = (r_state == LOAD);
    assign w_drop     = pix_valid && w_full && !w_pop;
    assign w_avail    = !w_empty || pix_valid;
    assign w_tick     = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_pixDone  = (r_state == SHIFT) && !r_hold && w_tick && r_sclk &&
                        (r_bitCnt == BIT_W'(BITS_PER_PIX - 1));
    assign w_frameEnd = w_pixDone && (r_frameCnt == FC_W'(PIXELS_PER_FRAME - 1));
    assign w_gapEnd   = (r_div == DIV_W'(2 * CLK_DIV - 2));

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:  if (w_avail) w_nextState = LOAD;
            LOAD:  w_nextState = SHIFT;
            SHIFT: begin
                if (r_hold) begin
                    if (w_avail) w_nextState = LOAD;
                end else if (w_pixDone) begin
                    if (w_frameEnd)   w_nextState = GAP;
                    else if (w_avail) w_nextState = LOAD;
                end
            end
            GAP:   if (w_gapEnd) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // cs_n trails the state by one cycle, so GAP plus the IDLE pass-through keeps it high for 2*CLK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_div       <= '0;
            r_bitCnt    <= '0;
            r_frameCnt  <= '0;
            r_hold      <= 1'b0;
            r_sclk      <= 1'b0;
            r_csN       <= 1'b1;
            r_dc        <= 1'b0;
            r_ovf       <= 1'b0;
            r_frameDone <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_busy      <= (w_nextState != IDLE);
            r_frameDone <= w_frameEnd;
            if (w_drop)       r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_csN  <= 1'b1;
                    r_dc   <= 1'b0;
                    r_sclk <= 1'b0;
                end
                LOAD: begin
                    r_shift  <= w_loadWord;
                    r_div    <= '0;
                    r_bitCnt <= '0;
                    r_hold   <= 1'b0;
                    r_sclk   <= 1'b0;
                    r_csN    <= 1'b0;
                    r_dc     <= 1'b1;
                end
                SHIFT: begin
                    if (!r_hold) begin
                        if (w_tick) begin
                            r_div  <= '0;
                            r_sclk <= !r_sclk;
                            if (r_sclk) begin
                                if (w_pixDone) begin
                                    r_frameCnt <= w_frameEnd ? '0 : r_frameCnt + 1'b1;
                                    r_hold     <= 1'b1;
                                end else begin
                                    r_bitCnt <= r_bitCnt + 1'b1;
                                    r_shift  <= {r_shift[RGB565_W-2:0], 1'b0};
                                end
                            end
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end
                end
                GAP: begin
                    r_csN <= 1'b1;
                    r_dc  <= 1'b0;
                    r_div <= r_div + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign spi_sclk   = r_sclk;
    assign spi_mosi   = r_shift[RGB565_W-1];
    assign spi_cs_n   = r_csN;
    assign spi_dc     = r_dc;
    assign overflow   = r_ovf;
    assign frame_done = r_frameDone;
    assign busy       = r_busy;

endmodule

// File: tb/tb_lcd_spi_pixel_tx.sv
// Directed bench for lcd_spi_pixel_tx with a serial-word scoreboard.
// Build with LCD_TX_BYTESWAP_EN to exercise the low-byte-first ordering.
module tb_lcd_spi_pixel_tx;

    localparam int FIFO_DEPTH = 4;
    localparam int CLK_DIV    = 2;
    localparam int PPF        = 3;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b1;
    logic [15:0]                   pix_data = 16'h0;
    logic                          pix_valid = 1'b0;
    logic                          clr_ovf = 1'b0;
    logic                          spi_sclk;
    logic                          spi_mosi;
    logic                          spi_cs_n;
    logic                          spi_dc;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          overflow;
    logic                          frame_done;
    logic                          busy;

    int          testsRun = 0;
    int          failCount = 0;
    logic [15:0] expQ[$];

    int          monPix = 0;
    int          monRise = 0;
    int          monCnt = 0;
    int          fdCount = 0;
    int          fdPixAt = 0;
    int          curRun = 0;
    int          lastRun = 0;
    int          maxLevel = 0;
    int          dcViol = 0;
    logic [15:0] monWord = 16'h0;
    logic        prevSclk = 1'b0;
    logic        prevCs = 1'b1;

    lcd_spi_pixel_tx #(
        .FIFO_DEPTH       (FIFO_DEPTH),
        .CLK_DIV          (CLK_DIV),
        .PIXELS_PER_FRAME (PPF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .clr_ovf    (clr_ovf),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .spi_dc     (spi_dc),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] serialOf(input logic [15:0] d);
`ifdef LCD_TX_BYTESWAP_EN
        return {d[7:0], d[15:8]};
`else
        return d;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input bit accept);
        @(negedge clk);
        pix_data  = d;
        pix_valid = 1'b1;
        if (accept) expQ.push_back(serialOf(d));
    endtask

    task automatic endStimulus();
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        pix_valid = 1'b0;
        clr_ovf   = 1'b0;
        #2 rst_n  = 1'b0;
        expQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitPixels(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (monPix >= target) break;
            @(negedge clk);
            #1;
        end
        checkOutput(tag, monPix, target);
    endtask

    // Decodes the serial stream on SCLK rising edges and scores each completed pixel.
    always @(negedge clk) begin
        if (!rst_n) begin
            monPix   = 0;
            monRise  = 0;
            monCnt   = 0;
            fdCount  = 0;
            fdPixAt  = 0;
            curRun   = 0;
            lastRun  = 0;
            maxLevel = 0;
            dcViol   = 0;
            prevSclk = 1'b0;
            prevCs   = 1'b1;
        end else begin
            if (spi_sclk && !prevSclk) begin
                monRise++;
                monWord = {monWord[14:0], spi_mosi};
                monCnt++;
                if (monCnt == 16) begin
                    logic [15:0] e;
                    monCnt = 0;
                    monPix++;
                    if (expQ.size() == 0) begin
                        checkOutput("pixel_unexpected", 32'(expQ.size()), 32'd1);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("pixel_data", 32'(monWord), 32'(e));
                    end
                end
            end
            if (int'(fifo_level) > maxLevel) maxLevel = int'(fifo_level);
            if (frame_done) begin
                fdCount++;
                fdPixAt = monPix;
            end
            if (!spi_cs_n && !spi_dc) dcViol++;
            if (spi_cs_n) begin
                if (!prevCs)        curRun = 1;
                else if (curRun > 0) curRun++;
            end else begin
                if (curRun > 0) lastRun = curRun;
                curRun = 0;
            end
            prevSclk = spi_sclk;
            prevCs   = spi_cs_n;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: run did not reach its summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] sw;
        int          csHigh;

        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_sclk",       32'(spi_sclk),   32'd0);
        checkOutput("rst_mosi",       32'(spi_mosi),   32'd0);
        checkOutput("rst_cs_n",       32'(spi_cs_n),   32'd1);
        checkOutput("rst_dc",         32'(spi_dc),     32'd0);
        checkOutput("rst_level",      32'(fifo_level), 32'd0);
        checkOutput("rst_overflow",   32'(overflow),   32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_busy",       32'(busy),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pixel: latency and bit order
        applyStimulus(16'hF800, 1'b1);
        endStimulus();
        checkOutput("single_level_n1", 32'(fifo_level), 32'd1);
        checkOutput("single_busy_n1",  32'(busy),       32'd1);
        checkOutput("single_cs_n1",    32'(spi_cs_n),   32'd1);
        @(negedge clk);
        sw = serialOf(16'hF800);
        checkOutput("single_cs_n2",   32'(spi_cs_n), 32'd0);
        checkOutput("single_mosi_n2", 32'(spi_mosi), 32'(sw[15]));
        checkOutput("single_dc_n2",   32'(spi_dc),   32'd1);
        checkOutput("single_sclk_n2", 32'(spi_sclk), 32'd0);
        @(negedge clk);
        checkOutput("single_sclk_n3", 32'(spi_sclk), 32'd0);
        @(negedge clk);
        checkOutput("single_sclk_n4", 32'(spi_sclk), 32'd1);
        waitPixels("single_pixels", 1, 200);
        repeat (20) @(negedge clk);
        checkOutput("single_rises", monRise, 16);
        checkOutput("single_dc_hold", dcViol, 0);
        checkOutput("single_queue", expQ.size(), 0);

        // Overflow: six back-to-back pushes into a four-deep FIFO
        resetDut();
        for (int i = 0; i < 6; i++) applyStimulus(16'hA5C0 ^ 16'(i * 16'h1111), i < 5);
        endStimulus();
        checkOutput("ovf_flag_set", 32'(overflow),   32'd1);
        checkOutput("ovf_level",    32'(fifo_level), 32'd4);
        waitPixels("ovf_pixels", 5, 1000);
        repeat (150) @(negedge clk);
        checkOutput("ovf_pixel_total", monPix, 5);
        checkOutput("ovf_queue",       expQ.size(), 0);
        checkOutput("ovf_peak_level",  maxLevel, 4);
        checkOutput("ovf_sticky",      32'(overflow), 32'd1);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        // Frame: three pixels per frame, fourth starts a new frame
        resetDut();
        for (int i = 0; i < 4; i++) applyStimulus(16'h0F0F + 16'(i * 16'h0123), 1'b1);
        endStimulus();
        waitPixels("frame_pixels", 4, 1000);
        repeat (10) @(negedge clk);
        checkOutput("frame_done_count", fdCount, 1);
        checkOutput("frame_done_after", fdPixAt, 3);
        checkOutput("frame_cs_gap",     lastRun, 2 * CLK_DIV);
        checkOutput("frame_queue",      expQ.size(), 0);

        // Underrun: FIFO runs dry mid-frame
        resetDut();
        applyStimulus(16'h5A3C, 1'b1);
        endStimulus();
        csHigh = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (spi_cs_n) csHigh++;
        end
        checkOutput("under_first_done", monPix, 1);
        checkOutput("under_rises_idle", monRise, 16);
        checkOutput("under_sclk_idle",  32'(spi_sclk), 32'd0);
        applyStimulus(16'hC3A5, 1'b1);
        endStimulus();
        for (int i = 0; i < 200; i++) begin
            if (monPix >= 2) break;
            @(negedge clk);
            #1;
            if (spi_cs_n) csHigh++;
        end
        checkOutput("under_second_done", monPix, 2);
        checkOutput("under_cs_low",      csHigh, 0);
        checkOutput("under_rises_total", monRise, 32);

        // Reset in the middle of a pixel
        resetDut();
        applyStimulus(16'hBEEF, 1'b0);
        applyStimulus(16'h1234, 1'b0);
        applyStimulus(16'h5678, 1'b0);
        endStimulus();
        for (int i = 0; i < 200; i++) begin
            if (monRise >= 8) break;
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < 20; i++) begin
            if (!spi_sclk) break;
            @(negedge clk);
            #1;
        end
        checkOutput("mid_rises", monRise, 8);
        checkOutput("mid_level", 32'(fifo_level), 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_sclk",  32'(spi_sclk),   32'd0);
        checkOutput("mid_rst_mosi",  32'(spi_mosi),   32'd0);
        checkOutput("mid_rst_cs_n",  32'(spi_cs_n),   32'd1);
        checkOutput("mid_rst_dc",    32'(spi_dc),     32'd0);
        checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
        checkOutput("mid_rst_busy",  32'(busy),       32'd0);
        expQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("mid_no_edges",   monRise, 0);
        checkOutput("mid_no_pixels",  monPix, 0);
        checkOutput("mid_idle_cs_n",  32'(spi_cs_n), 32'd1);
        checkOutput("mid_idle_busy",  32'(busy),     32'd0);

        // Byte order of a single asymmetric pixel
        resetDut();
        @(negedge clk);
        pix_data  = 16'h12AB;
        pix_valid = 1'b1;
`ifdef LCD_TX_BYTESWAP_EN
        expQ.push_back(16'hAB12);
`else
        expQ.push_back(16'h12AB);
`endif
        endStimulus();
        waitPixels("order_pixels", 1, 200);
        checkOutput("order_queue", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/lcd_spi_pixel_tx.md
# lcd_spi_pixel_tx

Downstream consumer of the colormap stage: accepts a stream of RGB565 pixels, which arrive as a valid-qualified word with no backpressure. It buffers them in a small synchronous FIFO and serializes them MSB-first onto a write-only SPI display link (mode 0). It frames pixels into display frames by asserting chip-select per frame and reports overflow and frame completion.

## Interface
Parameters:
- FIFO_DEPTH, 16: pixel FIFO entries; power of two, ≥2.
- CLK_DIV, 2: clk cycles per SCLK half-period; ≥1.
- PIXELS_PER_FRAME, 76800: pixels per display frame (320×240); ≥1.

Ports:
- clk, in, 1: single clock. All logic is synchronous to this clock.
- rst_n, in, 1: asynchronous, active-low reset.
- pix_data, in, 16: RGB565 pixel.
- pix_valid, in, 1: pix_data is valid this cycle. There is no ready signal.
- clr_ovf, in, 1: clears the overflow flag.
- spi_sclk, out, 1: serial clock; idles at 0.
- spi_mosi, out, 1: serial data.
- spi_cs_n, out, 1: chip select, active low.
- spi_dc, out, 1: data/command select; 1 while pixel data is sent.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- overflow, out, 1: sticky flag; a pixel was dropped.
- frame_done, out, 1: one-cycle pulse when a frame completes.
- busy, out, 1: 1 whenever the FSM is not in IDLE.

## Operation
- **Push.** A pixel is written when pix_valid=1 and the FIFO is not full.
  - If the FIFO is full and no pop occurs that cycle, the pixel is dropped and overflow is set.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted and the level is unchanged.
- **Overflow flag.** clr_ovf clears overflow. If clr_ovf and a drop occur in the same cycle, set wins.
- **FSM states: IDLE, LOAD, SHIFT, GAP.**
  - IDLE: spi_cs_n=1, spi_sclk=0, spi_dc=0. Goes to LOAD when the FIFO is non-empty.
  - LOAD, 1 cycle: pops the FIFO into a 16-bit shift register, resets the divider, drives spi_cs_n=0 and spi_dc=1. Goes to SHIFT.
  - SHIFT: 16 bits, mode 0. spi_mosi holds the current bit through the low phase. SCLK rises after CLK_DIV cycles and falls after another CLK_DIV cycles. The register shifts on each falling edge.
  - SHIFT exit, after the 16th falling edge:
    - frame pixel count == PIXELS_PER_FRAME: pulse frame_done, clear the count, go to GAP.
    - otherwise, FIFO non-empty: go to LOAD, with spi_cs_n held low.
    - otherwise, FIFO empty: stay in SHIFT-idle with spi_cs_n low, spi_sclk=0 and mosi held. Go to LOAD as soon as the FIFO becomes non-empty.
  - GAP: spi_cs_n=1 for 2·CLK_DIV cycles, then go to IDLE.
- **Frame counter.** Width is $clog2(PIXELS_PER_FRAME+1). It increments once per completed pixel and never exceeds PIXELS_PER_FRAME.
- **Reset mid-transfer.** Asynchronous reset immediately empties the FIFO and forces the outputs to their reset values. The partial pixel is discarded.

## Timing
- **Reset values:** spi_sclk=0, spi_mosi=0, spi_cs_n=1, spi_dc=0, fifo_level=0, overflow=0, frame_done=0, busy=0. All outputs are registered.
- **Latency:** push at cycle N into an empty FIFO in IDLE:
  - fifo_level=1 at N+1.
  - LOAD at N+1.
  - spi_cs_n=0 and spi_mosi=bit15 at N+2.
  - First SCLK rise at N+2+CLK_DIV.
- **Pixel period:** 32·CLK_DIV+1 cycles when streaming back-to-back. The upstream average rate must not exceed this; anything faster is lost as overflow.
- **frame_done:** asserted in the cycle after the final falling SCLK edge of the frame.

## Configuration
- LCD_TX_BYTESWAP_EN:
  - Defined: each pixel is sent as pix_data[7:0] followed by pix_data[15:8], each byte MSB-first. This serves panels expecting little-endian RGB565.
  - Undefined: bits are sent pix_data[15] down to pix_data[0].

## Structure
- Package lcd_tx_pkg holds:
  - RGB565_W=16
  - BITS_PER_PIX=16
  - the FSM state enum (IDLE, LOAD, SHIFT, GAP)
- Sub-module pixel_fifo: synchronous FIFO, parameterised by width and depth. It provides a level output and supports push and pop in the same cycle. The serializer FSM and the divider live in the top level.

## Test plan
- **Single pixel:** CLK_DIV=2, push 16'hF800 once. Expect:
  - mosi sampled on rising edges = 1111100000000000
  - 16 rising edges
  - spi_cs_n low from N+2
  - spi_dc=1 throughout the pixel
- **Overflow:** FIFO_DEPTH=4, pix_valid high for 6 consecutive cycles. Expect:
  - pixel 5 dropped
  - overflow=1
  - peak fifo_level=4
  - exactly 5 pixels shifted out
  - clr_ovf then returns overflow to 0
- **Frame:** PIXELS_PER_FRAME=3, push 4 pixels. Expect:
  - frame_done pulses once, after the 3rd pixel
  - spi_cs_n high for exactly 4 cycles (CLK_DIV=2)
  - the 4th pixel starts a new frame
- **Underrun:** push 1 pixel, wait 100 cycles, push 1 more. Expect:
  - spi_cs_n stays low throughout
  - no SCLK edges during the wait
  - the second pixel is correct
- **Reset:** assert rst_n low at bit 7 of a pixel. Expect:
  - outputs at reset values in the same cycle
  - fifo_level=0
  - no further SCLK edges
- **Byte swap:** with LCD_TX_BYTESWAP_EN, push 16'h12AB. Expect the serial order 0xAB then 0x12.
